cpu_trace_capture: RTL and testbench



---
 rtl/trace_pkg.sv | 21 ++
 rtl/trace_fifo.sv | 39 +++
 rtl/cpu_trace_capture.sv | 78 +++++++
 tb/tb_cpu_trace_capture.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: frame geometry, snapshot field offsets and serializer states shared by the trace capture block.
package trace_pkg;
    localparam int SNAP_W      = 92;
    localparam int FRAME_W     = 96;
    localparam int FRAME_BYTES = 12;
    localparam int PC_MSB      = 91;
    localparam int SP_MSB      = 75;
    localparam int REG_B_MSB   = 59;
    localparam int REG_A_LSB   = 4;
    localparam int FLAG_Z      = 3;
    localparam int FLAG_N      = 2;
    localparam int FLAG_H      = 1;
    localparam int FLAG_C      = 0;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} ser_state_t;

    // Queue entry is {drop_flag, snapshot}; the frame pads three zero bits after the flag.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [SNAP_W:0] entry);
        return {entry[SNAP_W], 3'b000, entry[SNAP_W-1:0]};
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with extra-MSB pointers; a push while full is ignored even if a pop lands the same edge.
module trace_fifo #(
    parameter int WIDTH      = 93,
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end
endmodule

// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: queues a CPU state snapshot per retire tick and streams each as a 12-byte frame, MSB byte first.
module cpu_trace_capture
    import trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DEPTH_LOG2 = 2,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  tick_in,
    input  logic [SNAP_W-1:0]     snap_in,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  busy
);
    ser_state_t         state;
    logic [FRAME_W-1:0] shreg;
    logic [3:0]         byte_idx;
    logic               drop_pending, full, empty, capture, accept, last, pop;
    logic [SNAP_W:0]    head;

    assign capture  = enable && tick_in;
    assign accept   = out_valid && out_ready;
    assign last     = accept && byte_idx == 4'(FRAME_BYTES-1);
    assign pop      = !empty && (state == IDLE || last);
    // Top of the shift register is the output byte, so it is registered and zero after reset or a drained frame.
    assign out_data = shreg[FRAME_W-1 -: 8];
    assign busy     = state != IDLE || fifo_level != '0;

    trace_fifo #(.WIDTH(SNAP_W+1), .DEPTH(FIFO_DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (capture),
        .pop   (pop),
        .din   ({drop_pending, snap_in}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_pending <= 1'b0;
            drop_count   <= '0;
        end else if (capture) begin
            drop_pending <= full;
            if (full && !(&drop_count)) drop_count <= drop_count + DROP_CNT_W'(1);
        end
    end

    // Reloading on the last accepted byte keeps back-to-back frames bubble-free.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            byte_idx  <= '0;
            out_valid <= 1'b0;
        end else if (pop) begin
            state     <= SEND;
            shreg     <= make_frame(head);
            byte_idx  <= '0;
            out_valid <= 1'b1;
        end else if (accept) begin
            shreg    <= shreg << 8;
            byte_idx <= byte_idx + 4'd1;
            if (last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_trace_capture.sv
// tb_cpu_trace_capture: vector table of single-frame snapshots plus directed stall, overflow, reset, streaming and enable sequences.
module tb_cpu_trace_capture;
    typedef struct {
        logic [91:0] snap;
        logic [95:0] frame;
    } vec_t;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b1;
    logic        tick_in   = 1'b0;
    logic        out_ready = 1'b0;
    logic [91:0] snap_in   = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [2:0]  fifo_level;
    logic [15:0] drop_count;
    logic        busy;
    int          total  = 0;
    int          passed = 0;
    int          cyc    = 0;
    logic [7:0]  rx_q[$];
    int          rx_cyc[$];
    vec_t        vecs[3];

    cpu_trace_capture #(.FIFO_DEPTH(4), .DEPTH_LOG2(2), .DROP_CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .tick_in    (tick_in),
        .snap_in    (snap_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;
    // A byte seen valid and ready here is taken on the next rising edge.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            rx_q.push_back(out_data);
            rx_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic tick(input logic [91:0] s);
        snap_in = s;
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check("byte_count", 96'(rx_q.size()), 96'(n));
    endtask

    function automatic logic [95:0] frame_at(input int k);
        logic [95:0] f = '0;
        for (int i = 0; i < 12; i++) f = {f[87:0], rx_q[12*k+i]};
        return f;
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{92'h0100FFFE001300D8014D01B, 96'h00100FFFE001300D8014D01B};
        vecs[1] = '{92'h123456789ABCDEF01122334, 96'h0123456789ABCDEF01122334};
        vecs[2] = '{{92{1'b1}}, {4'h0, {92{1'b1}}}};

        #1 reset = 1'b0;
        step(2);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drops", drop_count, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        step(1);

        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            rx_q.delete();
            rx_cyc.delete();
            tick(vecs[v].snap);
            @(negedge clock);
            check("lat_valid_low", out_valid, 0);
            check("lat_level", fifo_level, 1);
            @(negedge clock);
            check("lat_valid_high", out_valid, 1);
            check("lat_byte0", out_data, vecs[v].frame[95:88]);
            wait_bytes(12, 40);
            check("frame", frame_at(0), vecs[v].frame);
            check("no_bubble", 96'(rx_cyc[11] - rx_cyc[0]), 11);
            check("idle_busy", busy, 0);
            check("idle_valid", out_valid, 0);
        end

        rx_q.delete();
        rx_cyc.delete();
        tick(vecs[0].snap);
        wait_bytes(4, 20);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("stall_data", out_data, 8'hE0);
            check("stall_valid", out_valid, 1);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        wait_bytes(12, 40);
        step(5);
        check("stall_count", 96'(rx_q.size()), 12);
        check("stall_frame", frame_at(0), vecs[0].frame);

        rx_q.delete();
        rx_cyc.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) tick({16'(i), 76'h0});
        check("ovf_level", fifo_level, 4);
        check("ovf_drops", drop_count, 1);
        check("ovf_valid", out_valid, 1);
        out_ready = 1'b1;
        step(13);
        tick({16'h0007, 76'h0});
        wait_bytes(72, 120);
        for (int k = 0; k < 6; k++) begin
            logic [15:0] pc;
            pc = (k < 5) ? 16'(k + 1) : 16'h0007;
            check("ovf_frame", frame_at(k), {(k == 5), 3'b000, pc, 76'h0});
        end
        check("ovf_drops_final", drop_count, 1);

        rx_q.delete();
        rx_cyc.delete();
        out_ready = 1'b0;
        tick({16'h000A, 76'h0});
        tick({16'h000B, 76'h0});
        tick({16'h000C, 76'h0});
        out_ready = 1'b1;
        wait_bytes(6, 20);
        check("pre_rst_level", fifo_level, 2);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_busy", busy, 0);
        step(2);
        reset = 1'b1;
        step(20);
        check("post_rst_quiet", 96'(rx_q.size()), 6);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_drops", drop_count, 0);
        check("post_rst_level", fifo_level, 0);

        rx_q.delete();
        rx_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            tick({16'(i + 256), 76'h5});
            step(11);
        end
        wait_bytes(240, 60);
        check("stream_gapless", 96'(rx_cyc[239] - rx_cyc[0]), 239);
        for (int k = 0; k < 20; k++) check("stream_frame", frame_at(k), {4'h0, 16'(k + 256), 76'h5});
        check("stream_drops", drop_count, 0);

        rx_q.delete();
        rx_cyc.delete();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick({16'hBEEF, 76'h0});
        step(30);
        check("disabled_quiet", 96'(rx_q.size()), 0);
        check("disabled_level", fifo_level, 0);
        enable = 1'b1;
        tick({16'h0055, 76'h0});
        wait_bytes(12, 40);
        step(20);
        check("enable_count", 96'(rx_q.size()), 12);
        check("enable_frame", frame_at(0), {4'h0, 16'h0055, 76'h0});
        check("enable_drops", drop_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
